// File: rtl/rng_pkg.sv
// Shared constants for the LFSR random number generator: legal widths,
// maximal-length Galois tap masks and the default seed.
package rng_pkg;

  localparam int NUM_WIDTHS = 4;
  localparam int unsigned DEFAULT_SEED = 1;

  localparam int LEGAL_WIDTHS [NUM_WIDTHS] = '{8, 16, 24, 32};
  localparam logic [31:0] TAPS_TABLE [NUM_WIDTHS] =
    '{32'h0000_00B8, 32'h0000_B400, 32'h00E1_0000, 32'h8020_0003};

  function automatic bit width_legal(input int width);
    width_legal = 1'b0;
    for (int i = 0; i < NUM_WIDTHS; i++)
      if (LEGAL_WIDTHS[i] == width) width_legal = 1'b1;
  endfunction

  // Returns zero for an unsupported width so a bad build is obvious in simulation.
  function automatic logic [31:0] taps_for(input int width);
    taps_for = 32'h0;
    for (int i = 0; i < NUM_WIDTHS; i++)
      if (LEGAL_WIDTHS[i] == width) taps_for = TAPS_TABLE[i];
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Right-shifting Galois LFSR state register with load and step controls.
// load wins over step; next is the combinational successor of the current state.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  localparam logic [31:0] TAPS_FULL = taps_for(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_reg;

  assign next  = state_reg[0] ? ((state_reg >> 1) ^ TAPS) : (state_reg >> 1);
  assign state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else if (load) begin
      state_reg <= load_value;
    end else if (step) begin
      state_reg <= next;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random word generator with valid/ready output handshake and lockup recovery.
// Optional output whitening is enabled by defining LFSR_RNG_WHITEN_EN.
module lfsr_rng
  import rng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] rand_num,
  output logic             lockup
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next;
  logic [WIDTH-1:0] load_value;
  logic [OUT_W-1:0] word_next;
  logic             state_zero;
  logic             advance;
  logic             core_load;

  logic             out_valid_reg;
  logic [OUT_W-1:0] rand_num_reg;
  logic             lockup_reg;

  assign state_zero = (state == '0);
  assign advance    = enable && (!out_valid_reg || out_ready);
  assign core_load  = seed_load || state_zero;
  // A zero seed would park the LFSR in its dead state, so fall back to SEED.
  assign load_value = (seed_load && (seed_in != '0)) ? seed_in : SEED;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (advance),
    .load       (core_load),
    .load_value (load_value),
    .state      (state),
    .next       (next)
  );

`ifdef LFSR_RNG_WHITEN_EN
  // Fold the top OUT_W bits onto the bottom ones to decorrelate adjacent words.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_whiten
    assign word_next[gi] = next[gi] ^ next[WIDTH-OUT_W+gi];
  end
`else
  logic unused_next;
  assign unused_next = ^next;
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_plain
    assign word_next[gi] = next[gi];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      rand_num_reg  <= '0;
      lockup_reg    <= 1'b0;
    end else if (seed_load) begin
      out_valid_reg <= 1'b0;
      lockup_reg    <= 1'b0;
    end else if (state_zero) begin
      // Recovery edge: the core reloads SEED and no new word is produced.
      lockup_reg <= 1'b1;
      if (out_ready) out_valid_reg <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= 1'b1;
      rand_num_reg  <= word_next;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign rand_num  = rand_num_reg;
  assign lockup    = lockup_reg;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed sequences plus randomized handshake
// against a sequence-level reference model (8-bit and 16-bit instances).
module tb_lfsr_rng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en8, sl8, rdy8, ov8, lk8;
  logic [7:0] sin8, rn8;
  logic       en16, sl16, rdy16, ov16, lk16;
  logic [15:0] sin16;
  logic [7:0]  rn16;

  lfsr_rng #(.WIDTH(8), .OUT_W(8), .SEED(8'h01)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .seed_load(sl8), .seed_in(sin8),
    .out_ready(rdy8), .out_valid(ov8), .rand_num(rn8), .lockup(lk8)
  );

  lfsr_rng #(.WIDTH(16), .OUT_W(8), .SEED(16'h0001)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(en16), .seed_load(sl16), .seed_in(sin16),
    .out_ready(rdy16), .out_valid(ov16), .rand_num(rn16), .lockup(lk16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One step of the Galois LFSR as the rule defines it, using the published taps.
  function automatic logic [31:0] gal(input logic [31:0] x, input int w);
    logic [31:0] taps;
    taps = (w == 8) ? 32'hB8 : 32'hB400;
    return (x >> 1) ^ (x[0] ? taps : 32'h0);
  endfunction

  function automatic logic [7:0] f16(input logic [15:0] x);
`ifdef LFSR_RNG_WHITEN_EN
    return x[7:0] ^ x[15:8];
`else
    return x[7:0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    en8 = 1'b0; en16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  logic [7:0]  exp_seq [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [31:0] m_state;
  logic        m_valid;
  logic [7:0]  m_rand;
  bit          seen8 [256];
  bit          seen16 [65536];
  int          dups;

  initial begin
    rst_n = 1'b0;
    en8 = 0; sl8 = 0; rdy8 = 0; sin8 = '0;
    en16 = 0; sl16 = 0; rdy16 = 0; sin16 = '0;
    #12;
    check_eq("rst_valid8", ov8, 0);
    check_eq("rst_rand8", rn8, 0);
    check_eq("rst_lockup8", lk8, 0);
    check_eq("rst_state8", dut8.state, 8'h01);
    check_eq("rst_state16", dut16.state, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running sequence from SEED
    en8 = 1; rdy8 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("seq_word%0d", i), rn8, exp_seq[i]);
      check_eq($sformatf("seq_valid%0d", i), ov8, 1);
    end

    // Back-pressure stall then resume
    pulse_reset();
    en8 = 1; rdy8 = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_word", rn8, 8'hB8);
      check_eq("stall_valid", ov8, 1);
    end
    rdy8 = 1;
    tick();
    check_eq("resume_word", rn8, 8'h5C);

    // Zero seed falls back to SEED
    en8 = 0; sl8 = 1; sin8 = 8'h00;
    tick();
    sl8 = 0;
    check_eq("zseed_state", dut8.state, 8'h01);
    check_eq("zseed_valid", ov8, 0);
    check_eq("zseed_rand_held", rn8, 8'h5C);
    en8 = 1;
    tick();
    check_eq("zseed_next", rn8, 8'hB8);

    // Consumption without enable clears valid, holds state and word
    en8 = 0; rdy8 = 1;
    tick();
    check_eq("drain_valid", ov8, 0);
    check_eq("drain_rand", rn8, 8'hB8);
    check_eq("drain_state", dut8.state, 8'hB8);

    // Lockup: state forced to zero across one edge
    @(posedge clk);
    #1 force dut8.state = 8'h00;
    tick();
    release dut8.state;
    #1;
    check_eq("lock_flag", lk8, 1);
    check_eq("lock_state", dut8.state, 8'h01);
    check_eq("lock_valid", ov8, 0);
    tick();
    check_eq("lock_sticky", lk8, 1);
    sl8 = 1; sin8 = 8'h5A;
    tick();
    sl8 = 0;
    check_eq("lock_clear", lk8, 0);
    check_eq("lock_reseed", dut8.state, 8'h5A);

    // Randomized handshake against the sequence model
    pulse_reset();
    m_state = 32'h1; m_valid = 0; m_rand = 8'h0;
    for (int i = 0; i < 300; i++) begin
      en8  = ($urandom_range(0, 3) != 0);
      rdy8 = ($urandom_range(0, 2) != 0);
      if (en8 && (!m_valid || rdy8)) begin
        m_state = gal(m_state, 8);
        m_rand  = m_state[7:0];
        m_valid = 1;
      end else if (m_valid && rdy8) begin
        m_valid = 0;
      end
      tick();
      check_eq("rnd_valid", ov8, m_valid);
      check_eq("rnd_rand", rn8, m_rand);
      check_eq("rnd_state", dut8.state, m_state);
    end

    // Full period, 8-bit
    pulse_reset();
    en8 = 1; rdy8 = 1; dups = 0;
    foreach (seen8[k]) seen8[k] = 0;
    seen8[1] = 1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 255) begin
        if (seen8[dut8.state] || dut8.state == 8'h00) dups++;
        seen8[dut8.state] = 1;
      end
    end
    check_eq("period8_dups", dups, 0);
    check_eq("period8_wrap", dut8.state, 8'h01);
    en8 = 0;

    // Full period, 16-bit
    en16 = 1; rdy16 = 1; dups = 0;
    seen16[1] = 1;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i < 65535) begin
        if (seen16[dut16.state] || dut16.state == 16'h0) dups++;
        seen16[dut16.state] = 1;
      end
    end
    check_eq("period16_dups", dups, 0);
    check_eq("period16_wrap", dut16.state, 16'h0001);
    check_eq("period16_word", rn16, f16(16'h0001));

    // Seeded 16-bit run with random handshake
    en16 = 0; sl16 = 1; sin16 = 16'h1234;
    tick();
    sl16 = 0;
    check_eq("seed16_state", dut16.state, 16'h1234);
    check_eq("seed16_valid", ov16, 0);
    m_state = 32'h1234; m_valid = 0; m_rand = rn16;
    for (int i = 0; i < 100; i++) begin
      en16  = ($urandom_range(0, 3) != 0);
      rdy16 = ($urandom_range(0, 1) != 0);
      if (en16 && (!m_valid || rdy16)) begin
        m_state = gal(m_state, 16);
        m_rand  = f16(m_state[15:0]);
        m_valid = 1;
      end else if (m_valid && rdy16) begin
        m_valid = 0;
      end
      tick();
      check_eq("w16_valid", ov16, m_valid);
      check_eq("w16_rand", rn16, m_rand);
    end

    // Reset asserted during a stall
    en16 = 1; rdy16 = 0;
    tick();
    check_eq("mid_pre_valid", ov16, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_valid", ov16, 0);
    check_eq("mid_rand", rn16, 0);
    check_eq("mid_state", dut16.state, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    rdy16 = 1;
    tick();
    check_eq("mid_first", rn16, f16(16'hB400));
    check_eq("mid_first_valid", ov16, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 SHALL have parameter WIDTH, default 16, LFSR state width; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter OUT_W, default 8, output word width; legal range 1..WIDTH.
REQ-003 SHALL have parameter SEED, default 1, reset and fallback seed; must be nonzero.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  permits generation of new words.
REQ-007 SHALL have port seed_load  input  1  loads seed_in into the LFSR.
REQ-008 SHALL have port seed_in  input  WIDTH  seed value.
REQ-009 SHALL have port out_ready  input  1  consumer accepts rand_num.
REQ-010 SHALL have port out_valid  output  1  rand_num holds a fresh, unconsumed word.
REQ-011 SHALL have port rand_num  output  OUT_W  random word.
REQ-012 SHALL have port lockup  output  1  sticky flag, all-zero state detected.

Function
REQ-013 SHALL implement a right-shifting Galois LFSR: if state[0]=1, next = (state>>1) XOR TAPS[WIDTH], else next = state>>1.
REQ-014 SHALL use TAPS of 0xB8 (WIDTH 8), 0xB400 (16), 0xE10000 (24) and 0x80200003 (32), all maximal-length (period 2^WIDTH-1).
REQ-015 SHALL define advance = enable AND (NOT out_valid OR out_ready).
REQ-016 SHALL, on advance, update state <= next, rand_num <= f(next) and out_valid <= 1 in the same edge; latency is 1 cycle from enable to first out_valid.
REQ-017 SHALL define f(x) = x[OUT_W-1:0] when whitening is compiled out.
REQ-018 SHALL, when out_valid=1 and out_ready=0, hold state, rand_num and out_valid unchanged regardless of enable.
REQ-019 SHALL, when enable=0, out_valid=1 and out_ready=1, clear out_valid and hold state and rand_num.
REQ-020 SHALL, when enable=0 and out_valid=0, hold everything.
REQ-021 SHALL give seed_load priority over advance: state <= seed_in, or SEED if seed_in=0; out_valid <= 0; lockup <= 0; rand_num held.
REQ-022 SHALL, if state is ever 0 without seed_load, load SEED on that edge instead of next, set lockup <= 1 and produce no word.
REQ-023 SHALL keep lockup set until seed_load or reset.
REQ-024 SHALL never present state 0 after any edge.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=SEED, rand_num=0, out_valid=0 and lockup=0.
REQ-026 SHALL discard an unaccepted word on reset mid-operation; the first advance after release yields f(next(SEED)).

Configuration
REQ-027 SHALL provide macro LFSR_RNG_WHITEN_EN; when defined, f(x) = x[OUT_W-1:0] XOR x[WIDTH-1 -: OUT_W].
REQ-028 SHALL, when LFSR_RNG_WHITEN_EN is not defined, use f per REQ-017 with no extra logic; handshake and latency are identical in both builds.

Structure
REQ-029 SHALL take the TAPS table, the tap-lookup function, the default SEED and the legal WIDTH list from shared package rng_pkg.
REQ-030 SHALL contain one sub-module, lfsr_core: it holds the state register with step, load and load_value inputs and provides the state and next outputs.
REQ-031 SHALL implement the handshake, lockup and whitening logic in lfsr_rng.

Verification (WIDTH=8, OUT_W=8, SEED=1, whitening off unless noted)
REQ-032 SHALL check: reset, then enable=1 with out_ready=1 -> rand_num sequence 0xB8, 0x5C, 0x2E, 0x17, 0xB3 on consecutive cycles, with out_valid high from the first cycle.
REQ-033 SHALL check: out_ready=0 for 5 cycles while enable=1 -> rand_num stuck at 0xB8 and out_valid=1; on ready return, the next word is 0x5C with no skipped value.
REQ-034 SHALL check: seed_load with seed_in=0x00 -> state=0x01 and out_valid=0; the next advance gives 0xB8.
REQ-035 SHALL check: free-run for 255 advances from SEED -> state returns to 0x01, and no repeat or zero occurs earlier; repeat the check with WIDTH=16 for 65535 advances.
REQ-036 SHALL check: force state to 0 for one cycle -> lockup=1, state=0x01 and no valid pulse; lockup clears on seed_load.
REQ-037 SHALL check: with LFSR_RNG_WHITEN_EN, WIDTH=16, OUT_W=8 and seed 0x1234 -> each rand_num equals state[7:0] XOR state[15:8]; also check rst_n asserted mid-stall -> out_valid=0 immediately.
